// File: rtl/mem_arb_pkg.sv
// Shared types, defaults and parameter sanity check for the IF/MEM memory port arbiter.
package mem_arb_pkg;

  localparam int DEF_ADDR_WIDTH     = 32;
  localparam int DEF_DATA_WIDTH     = 32;
  localparam int DEF_MAX_D_STREAK   = 4;
  localparam int DEF_TIMEOUT_CYCLES = 16;

  localparam int STREAK_W = 4;
  localparam int TIMER_W  = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_BUSY_IF = 3'd1,
    ST_BUSY_D  = 3'd2,
    ST_RESP_IF = 3'd3,
    ST_RESP_D  = 3'd4
  } arb_state_e;

  typedef enum logic {
    GNT_IF = 1'b0,
    GNT_D  = 1'b1
  } gnt_src_e;

  function automatic bit params_ok(int aw, int dw, int max_streak, int timeout);
    return (aw > 0) && (dw >= 8) && (dw % 8 == 0) &&
           (max_streak >= 1) && (max_streak <= 15) &&
           (timeout >= 2) && (timeout <= 255);
  endfunction

endpackage

// File: rtl/mem_arb_timer.sv
// Clear/enable up-counter with a terminal-count flag; drives the memory timeout.
module mem_arb_timer #(
  parameter int             W        = 8,
  parameter logic [W-1:0]   TERMINAL = '1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  logic [W-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n)   r_count <= '0;
    else if (i_clr) r_count <= '0;
    else if (i_en)  r_count <= r_count + W'(1);
  end

  assign o_tc = (r_count == TERMINAL);

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch and load/store: one transaction
// at a time, data priority with a fetch starvation guard, and a timeout on stuck memory.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int MAX_D_STREAK   = DEF_MAX_D_STREAK,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_if_req,
  input  logic [ADDR_WIDTH-1:0]   i_if_addr,
  output logic                    o_if_rvalid,
  output logic [DATA_WIDTH-1:0]   o_if_rdata,
  output logic                    o_if_err,
  input  logic                    i_d_req,
  input  logic                    i_d_we,
  input  logic [ADDR_WIDTH-1:0]   i_d_addr,
  input  logic [DATA_WIDTH-1:0]   i_d_wdata,
  input  logic [DATA_WIDTH/8-1:0] i_d_be,
  output logic                    o_d_rvalid,
  output logic [DATA_WIDTH-1:0]   o_d_rdata,
  output logic                    o_d_err,
  output logic                    o_mem_req,
  output logic                    o_mem_we,
  output logic [ADDR_WIDTH-1:0]   o_mem_addr,
  output logic [DATA_WIDTH-1:0]   o_mem_wdata,
  output logic [DATA_WIDTH/8-1:0] o_mem_be,
  input  logic                    i_mem_ready,
  input  logic [DATA_WIDTH-1:0]   i_mem_rdata
);

  localparam int                  BE_W       = DATA_WIDTH / 8;
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);
  localparam logic [TIMER_W-1:0]  TMO_LAST   = TIMER_W'(TIMEOUT_CYCLES - 1);

  if (!params_ok(ADDR_WIDTH, DATA_WIDTH, MAX_D_STREAK, TIMEOUT_CYCLES)) begin : g_param_err
    $error("mem_port_arbiter: parameter out of range");
  end

  arb_state_e              r_state, w_state_nxt;
  gnt_src_e                w_gnt_src;
  logic                    w_grant;
  logic                    w_busy;
  logic                    w_idle_clr;
  logic                    w_tmo;
  logic                    w_finish;
  logic [DATA_WIDTH-1:0]   w_rdata_cap;

  logic                    r_we;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [DATA_WIDTH-1:0]   r_wdata;
  logic [BE_W-1:0]         r_be;
  logic                    r_err;
  logic [DATA_WIDTH-1:0]   r_if_rdata;
  logic [DATA_WIDTH-1:0]   r_d_rdata;
  logic [STREAK_W-1:0]     r_d_streak;

  assign w_busy     = (r_state == ST_BUSY_IF) || (r_state == ST_BUSY_D);
  assign w_idle_clr = !w_busy;
  // mem_ready on the terminal cycle wins over the timeout.
  assign w_finish   = w_busy && (i_mem_ready || w_tmo);
  assign w_rdata_cap = (i_mem_ready && !r_we) ? i_mem_rdata : '0;

  mem_arb_timer #(
    .W        (TIMER_W),
    .TERMINAL (TMO_LAST)
  ) u_timer (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (w_idle_clr),
    .i_en    (w_busy),
    .o_tc    (w_tmo)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_gnt_src   = GNT_D;
    case (r_state)
      ST_IDLE: begin
        if (i_d_req && i_if_req) begin
          w_grant   = 1'b1;
          w_gnt_src = (r_d_streak == STREAK_MAX) ? GNT_IF : GNT_D;
        end else if (i_d_req) begin
          w_grant   = 1'b1;
          w_gnt_src = GNT_D;
        end else if (i_if_req) begin
          w_grant   = 1'b1;
          w_gnt_src = GNT_IF;
        end
        if (w_grant) w_state_nxt = (w_gnt_src == GNT_IF) ? ST_BUSY_IF : ST_BUSY_D;
      end
      ST_BUSY_IF: if (w_finish) w_state_nxt = ST_RESP_IF;
      ST_BUSY_D:  if (w_finish) w_state_nxt = ST_RESP_D;
      ST_RESP_IF: w_state_nxt = ST_IDLE;
      ST_RESP_D:  w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state    <= ST_IDLE;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_be       <= '0;
      r_err      <= 1'b0;
      r_if_rdata <= '0;
      r_d_rdata  <= '0;
      r_d_streak <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_grant) begin
        if (w_gnt_src == GNT_IF) begin
          r_we       <= 1'b0;
          r_addr     <= i_if_addr;
          r_wdata    <= '0;
          r_be       <= '1;
          r_d_streak <= '0;
        end else begin
          r_we    <= i_d_we;
          r_addr  <= i_d_addr;
          r_wdata <= i_d_wdata;
          r_be    <= i_d_be;
          // Streak only grows while fetch is actually waiting.
          if (!i_if_req)                    r_d_streak <= '0;
          else if (r_d_streak != STREAK_MAX) r_d_streak <= r_d_streak + 4'd1;
        end
      end
      if (w_finish) begin
        r_err <= !i_mem_ready;
        if (r_state == ST_BUSY_IF) r_if_rdata <= w_rdata_cap;
        else                       r_d_rdata  <= w_rdata_cap;
      end
    end
  end

  assign o_mem_req   = w_busy;
  assign o_mem_we    = w_busy && r_we;
  assign o_mem_addr  = w_busy ? r_addr  : '0;
  assign o_mem_wdata = w_busy ? r_wdata : '0;
  assign o_mem_be    = w_busy ? r_be    : '0;

  assign o_if_rvalid = (r_state == ST_RESP_IF);
  assign o_if_rdata  = r_if_rdata;
  assign o_if_err    = o_if_rvalid && r_err;
  assign o_d_rvalid  = (r_state == ST_RESP_D);
  assign o_d_rdata   = r_d_rdata;
  assign o_d_err     = o_d_rvalid && r_err;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: vector table, scoreboard queues, memory model.
module tb_mem_port_arbiter;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req, d_req, d_we, mem_ready;
  logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
  logic [3:0]  d_be;
  logic        if_rvalid, if_err, d_rvalid, d_err;
  logic [31:0] if_rdata, d_rdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_D_STREAK(4), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_if_req(if_req), .i_if_addr(if_addr),
    .o_if_rvalid(if_rvalid), .o_if_rdata(if_rdata), .o_if_err(if_err),
    .i_d_req(d_req), .i_d_we(d_we), .i_d_addr(d_addr), .i_d_wdata(d_wdata), .i_d_be(d_be),
    .o_d_rvalid(d_rvalid), .o_d_rdata(d_rdata), .o_d_err(d_err),
    .o_mem_req(mem_req), .o_mem_we(mem_we), .o_mem_addr(mem_addr),
    .o_mem_wdata(mem_wdata), .o_mem_be(mem_be),
    .i_mem_ready(mem_ready), .i_mem_rdata(mem_rdata)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Scoreboard entries are {err, rdata}.
  logic [32:0] if_q[$];
  logic [32:0] d_q[$];

  // Memory model: ready in the lat-th cycle of mem_req (lat==0 never answers).
  int          lat = 1;
  logic [31:0] mem_data = '0;
  int          busy_cnt = 0;

  initial begin
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (mem_req) busy_cnt++;
      else         busy_cnt = 0;
      mem_ready = (lat != 0) && (busy_cnt == lat);
      mem_rdata = mem_ready ? mem_data : 32'hBAD0BAD0;
    end
  end

  logic        chk_mem = 1'b0;
  logic        exp_we;
  logic [31:0] exp_addr, exp_wdata;
  logic [3:0]  exp_be;

  initial begin
    logic [32:0] e;
    forever begin
      @(negedge clk);
      if (if_rvalid) begin
        if (if_q.size() == 0) chk("if_unexpected_rvalid", 32'(if_rvalid), 32'd0);
        else begin
          e = if_q.pop_front();
          chk("if_rdata", if_rdata, e[31:0]);
          chk("if_err", 32'(if_err), 32'(e[32]));
        end
      end
      if (d_rvalid) begin
        if (d_q.size() == 0) chk("d_unexpected_rvalid", 32'(d_rvalid), 32'd0);
        else begin
          e = d_q.pop_front();
          chk("d_rdata", d_rdata, e[31:0]);
          chk("d_err", 32'(d_err), 32'(e[32]));
        end
      end
      if (chk_mem && mem_req) begin
        chk("mem_we", 32'(mem_we), 32'(exp_we));
        chk("mem_addr", mem_addr, exp_addr);
        chk("mem_be", 32'(mem_be), 32'(exp_be));
        if (exp_we) chk("mem_wdata", mem_wdata, exp_wdata);
      end
    end
  end

  typedef struct {
    logic        is_d;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          lat;
    logic [31:0] mdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[7];

  task automatic run_vec(input vec_t v, input int idx);
    int   cycles, req_cyc, busy_len;
    logic done, rv;
    @(negedge clk);
    lat      = v.lat;
    mem_data = v.mdata;
    exp_we   = v.is_d ? v.we : 1'b0;
    exp_addr = v.addr;
    exp_wdata = v.wdata;
    exp_be   = v.is_d ? v.be : 4'hF;
    chk_mem  = 1'b1;
    if (v.is_d) begin
      d_q.push_back({v.exp_err, v.exp_rdata});
      d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata; d_be = v.be;
    end else begin
      if_q.push_back({v.exp_err, v.exp_rdata});
      if_req = 1'b1; if_addr = v.addr;
    end
    cycles = 0; req_cyc = 0; done = 1'b0;
    for (int c = 0; c < 100 && !done; c++) begin
      @(negedge clk);
      cycles++;
      if (mem_req) req_cyc++;
      rv = v.is_d ? d_rvalid : if_rvalid;
      if (rv) done = 1'b1;
    end
    chk($sformatf("v%0d_rvalid_seen", idx), 32'(done), 32'd1);
    if_req = 1'b0; d_req = 1'b0;
    chk_mem = 1'b0;
    busy_len = (v.lat == 0 || v.lat > TMO) ? TMO : v.lat;
    chk($sformatf("v%0d_latency", idx), 32'(cycles), 32'(busy_len + 1));
    chk($sformatf("v%0d_mem_req_cycles", idx), 32'(req_cyc), 32'(busy_len));
    @(negedge clk);
    rv = v.is_d ? d_rvalid : if_rvalid;
    chk($sformatf("v%0d_single_pulse", idx), 32'(rv), 32'd0);
    chk($sformatf("v%0d_err_low_after", idx), 32'(v.is_d ? d_err : if_err), 32'd0);
    chk($sformatf("v%0d_rdata_hold", idx), v.is_d ? d_rdata : if_rdata, v.exp_rdata);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int   n, prev_t, t;
    logic done;
    logic order[10];
    logic exp_order[10];
    int   b2b_lat[6];

    rst_n = 1'b0; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    if_addr = '0; d_addr = '0; d_wdata = '0; d_be = '0;

    vecs[0] = '{1'b0, 1'b0, 32'h100,  32'h0,        4'h0,    1, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 32'h2004, 32'h12345678, 4'b0011, 2, 32'hCAFEF00D, 32'h0,        1'b0};
    vecs[2] = '{1'b1, 1'b0, 32'h2008, 32'h0,        4'hF,    3, 32'h0BADF00D, 32'h0BADF00D, 1'b0};
    vecs[3] = '{1'b0, 1'b0, 32'h300,  32'h0,        4'h0,    0, 32'h77777777, 32'h0,        1'b1};
    vecs[4] = '{1'b0, 1'b0, 32'h104,  32'h0,        4'h0,    1, 32'h13579BDF, 32'h13579BDF, 1'b0};
    vecs[5] = '{1'b1, 1'b0, 32'h200C, 32'h0,        4'hF,  TMO, 32'hA5A5A5A5, 32'hA5A5A5A5, 1'b0};
    vecs[6] = '{1'b1, 1'b1, 32'h2010, 32'hFFFF0000, 4'b1100, 0, 32'h55555555, 32'h0,        1'b1};

    repeat (3) @(negedge clk);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_if_rvalid", 32'(if_rvalid), 32'd0);
    chk("rst_d_rvalid", 32'(d_rvalid), 32'd0);
    chk("rst_if_rdata", if_rdata, 32'd0);
    chk("rst_d_rdata", d_rdata, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

    // Back-to-back loads with d_req held; rvalid spacing is ready latency + 2.
    b2b_lat = '{1, 1, 2, 3, 4, 5};
    @(negedge clk);
    chk_mem = 1'b1; exp_we = 1'b0; exp_be = 4'hF; exp_addr = 32'h2000;
    lat = b2b_lat[0]; mem_data = 32'h10000000;
    d_q.push_back({1'b0, 32'h10000000});
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h2000; d_be = 4'hF;
    t = 0; prev_t = 0;
    for (int k = 0; k < 6; k++) begin
      done = 1'b0;
      for (int c = 0; c < 50 && !done; c++) begin
        @(negedge clk);
        t++;
        if (d_rvalid) done = 1'b1;
      end
      chk($sformatf("b2b%0d_rvalid_seen", k), 32'(done), 32'd1);
      if (k > 0) chk($sformatf("b2b%0d_period", k), 32'(t - prev_t), 32'(b2b_lat[k] + 2));
      prev_t = t;
      if (k < 5) begin
        d_addr = 32'h3000 + 32'(4 * k); exp_addr = d_addr;
        lat = b2b_lat[k + 1]; mem_data = 32'h10000001 + 32'(k);
        d_q.push_back({1'b0, 32'h10000001 + 32'(k)});
      end else d_req = 1'b0;
    end
    chk_mem = 1'b0;

    // Contention: both held, four data grants then one fetch, repeating.
    exp_order = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
    @(negedge clk);
    lat = 1; mem_data = 32'h11112222;
    if_q.push_back({1'b0, 32'h11112222});
    d_q.push_back({1'b0, 32'h11112222});
    if_req = 1'b1; if_addr = 32'h100;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h2000; d_be = 4'hF;
    n = 0;
    for (int c = 0; c < 200 && n < 10; c++) begin
      @(negedge clk);
      if (if_rvalid) begin order[n] = 1'b0; n++; if_q.push_back({1'b0, 32'h11112222}); end
      if (d_rvalid && n < 10) begin order[n] = 1'b1; n++; d_q.push_back({1'b0, 32'h11112222}); end
    end
    if_req = 1'b0; d_req = 1'b0;
    chk("cont_grants_seen", 32'(n), 32'd10);
    for (int k = 0; k < n; k++) chk($sformatf("cont_order%0d", k), 32'(order[k]), 32'(exp_order[k]));
    @(negedge clk);
    @(negedge clk);
    if_q.delete(); d_q.delete();

    // Reset on the 2nd BUSY_D cycle of a stuck load; pending fetch served after release.
    @(negedge clk);
    lat = 0; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h4000; d_be = 4'hF;
    n = 0;
    for (int c = 0; c < 20 && n < 2; c++) begin
      @(negedge clk);
      if (mem_req) n++;
    end
    chk("rst_busy_reached", 32'(n), 32'd2);
    rst_n = 1'b0; d_req = 1'b0; if_req = 1'b1; if_addr = 32'h500;
    lat = 1; mem_data = 32'h600DD00D;
    if_q.push_back({1'b0, 32'h600DD00D});
    @(negedge clk);
    chk("midrst_mem_req", 32'(mem_req), 32'd0);
    chk("midrst_d_rvalid", 32'(d_rvalid), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("postrst_mem_req", 32'(mem_req), 32'd1);
    chk("postrst_mem_addr", mem_addr, 32'h500);
    chk("postrst_mem_we", 32'(mem_we), 32'd0);
    done = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk);
      if (if_rvalid) done = 1'b1;
    end
    if_req = 1'b0;
    chk("postrst_if_rvalid_seen", 32'(done), 32'd1);
    repeat (3) @(negedge clk);
    chk("final_if_q_empty", 32'(if_q.size()), 32'd0);
    chk("final_d_q_empty", 32'(d_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares one single-port unified memory between the instruction-fetch stage and the load/store (MEM) stage of the RISC-V pipeline. The block sequences one memory transaction at a time with a req/ack FSM. Data accesses get priority, with a starvation guard for fetch and a timeout for an unresponsive memory. It sits between the IF/MEM stages and the memory model; the pipeline's hazard logic stalls on outstanding requests.

Parameters:
ADDR_WIDTH, 32, byte address width
DATA_WIDTH, 32, data bus width
MAX_D_STREAK, 4, consecutive data grants allowed while fetch waits; range 1..15
TIMEOUT_CYCLES, 16, BUSY cycles without mem_ready before abort; range 2..255

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
if_req  in  1  fetch request; held high until if_rvalid
if_addr  in  ADDR_WIDTH  fetch address
if_rvalid  out  1  one-cycle fetch completion pulse
if_rdata  out  DATA_WIDTH  fetch data, valid with if_rvalid
if_err  out  1  timeout flag, valid with if_rvalid
d_req  in  1  data request; held high until d_rvalid
d_we  in  1  1=store, 0=load
d_addr  in  ADDR_WIDTH  data address
d_wdata  in  DATA_WIDTH  store data
d_be  in  DATA_WIDTH/8  byte enables
d_rvalid  out  1  one-cycle data completion pulse (loads and stores)
d_rdata  out  DATA_WIDTH  load data, valid with d_rvalid
d_err  out  1  timeout flag, valid with d_rvalid
mem_req  out  1  memory request, held until mem_ready or abort
mem_we  out  1  memory write enable
mem_addr  out  ADDR_WIDTH  memory address
mem_wdata  out  DATA_WIDTH  memory write data
mem_be  out  DATA_WIDTH/8  memory byte enables
mem_ready  in  1  memory completion, qualifies mem_rdata
mem_rdata  in  DATA_WIDTH  memory read data

Behaviour:
- Reset: rst_n sampled low at posedge. FSM goes to IDLE. All outputs are 0, d_streak=0 and timer=0. Reset mid-transaction abandons the memory access: mem_req drops next cycle and no rvalid is issued.
- FSM states: IDLE, BUSY_IF, BUSY_D, RESP_IF, RESP_D.
- Request sampling: req inputs are sampled only in IDLE.
- IDLE, grant decision:
  - Only d_req: grant D.
  - Only if_req: grant IF.
  - Both: grant IF if d_streak==MAX_D_STREAK, else grant D.
- On grant: latch addr/we/wdata/be into registers (if_grant sets we=0, be=all-ones). Assert mem_req. Go to BUSY_x.
- BUSY_x:
  - mem_* outputs are driven from the latched registers, stable for the whole state.
  - timer increments every cycle.
  - mem_ready=1: capture mem_rdata (forced 0 for stores), go to RESP_x, err=0.
  - timer==TIMEOUT_CYCLES-1 without mem_ready: go to RESP_x, rdata=0, err=1.
  - mem_ready on the timeout cycle counts as success.
- RESP_x: x_rvalid=1 for exactly one cycle, with registered x_rdata/x_err. mem_req=0. Go to IDLE; timer clears.
- Requester rule: drop req at the edge ending the rvalid cycle, or keep it high to start a new access. A req still high in IDLE is a new request.
- Latency: a 1-cycle-ready memory gives grant edge → BUSY (1 cycle) → RESP → IDLE, i.e. 3 cycles per access; throughput is 1 access per 3 cycles.
- Outside BUSY, mem_we/mem_addr/mem_wdata/mem_be are 0.
- Starvation counter d_streak (4 bits):
  - D grant while if_req=1: d_streak+1, saturating at MAX_D_STREAK.
  - D grant while if_req=0: d_streak=0.
  - IF grant: d_streak=0.
- Input changes during BUSY/RESP are ignored, because addresses are latched.
- x_rdata holds its last value between pulses. x_err is 0 outside rvalid.
- No combinational path from req to mem_*; all memory outputs are registered.

Decomposition:
- Package mem_arb_pkg holds:
  - the state enum encoding (3 bits)
  - grant-source constants GNT_IF / GNT_D
  - default widths and parameter range checks
- Natural sub-module: mem_arb_timer, an 8-bit clear/enable counter with terminal-count output used for the timeout.
- Arbitration and FSM stay in the top module.

Test Plan:
- Fetch only: if_req=1, if_addr=0x100; memory readies 1 cycle after mem_req with 0xDEADBEEF → mem_addr=0x100, mem_we=0; if_rvalid pulses 3 cycles after req, if_rdata=0xDEADBEEF, if_err=0.
- Store: d_req=1, d_we=1, d_addr=0x2004, d_wdata=0x12345678, d_be=4'b0011 → mem_* match for the whole of BUSY; d_rvalid pulses once with d_rdata=0.
- Contention, MAX_D_STREAK=4: if_req and d_req held continuously → grant order D,D,D,D,IF,D,D,D,D,IF; d_streak returns to 0 after each IF grant.
- Timeout, TIMEOUT_CYCLES=16: mem_ready tied 0 on a fetch → mem_req high exactly 16 cycles; if_rvalid=1, if_err=1, if_rdata=0; the next request is served normally.
- Reset mid-op: rst_n=0 on the 2nd BUSY_D cycle → next cycle mem_req=0, no d_rvalid, FSM IDLE; after release the pending if_req is granted first.
- Back-to-back: d_req held across d_rvalid with a new d_addr=0x3000 → second access to 0x3000 starts in the cycle after RESP; mem_ready latency varied 1..5 cycles gives rvalid at 3..7 cycles per access.
